handshake_constant_rr_arbiter: RTL

//  Shares one handshake constant source between N_REQ control requesters. Each

---
 rtl/handshake_constant_rr_arbiter.sv | 93 +++++++++
 1 files changed

// File: rtl/handshake_constant_rr_arbiter.sv
// Round-robin arbiter that turns one granted ctrl token into one constant output
// token, held in a one-slot registered buffer tagged with the winning requester.
module handshake_constant_rr_arbiter #(
    parameter int          DATA_WIDTH  = 32,
    parameter int          N_REQ       = 4,
    parameter int          IDX_W       = 2,
    parameter logic [16:0] CONST_VALUE = 17'b01001100101001111
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      ctrl_valid,
    output logic [N_REQ-1:0]      ctrl_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic [IDX_W-1:0]      outs_idx,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    localparam logic [DATA_WIDTH-1:0] CONST_EXT = DATA_WIDTH'(CONST_VALUE);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    slot_state_e      state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic             found;
    logic [IDX_W-1:0] winner;
    logic             can_load;
    logic             grant;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && ctrl_valid[(int'(ptr_q) + k) % N_REQ]) begin
                found  = 1'b1;
                winner = IDX_W'((int'(ptr_q) + k) % N_REQ);
            end
        end
    end

    assign can_load = (state_q == EMPTY) || outs_ready;
    assign grant    = rst && found && can_load;

    // Only the winner's ready is driven, so non-winner valids never reach ctrl_ready.
    always_comb begin
        ctrl_ready = '0;
        if (rst && found) begin
            ctrl_ready[winner] = can_load;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        if (grant) begin
            state_d = FULL;
            idx_d   = winner;
            ptr_d   = (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
        end else if (state_q == FULL && outs_ready) begin
            state_d = EMPTY;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
        end
    end

    assign outs_valid = (state_q == FULL);
    assign outs_idx   = idx_q;
    assign outs       = (state_q == FULL) ? CONST_EXT : '0;

    a_ready_onehot0: assert property (@(posedge clk) disable iff (!rst) $onehot0(ctrl_ready));

    a_hold_stable: assert property (@(posedge clk) disable iff (!rst)
        outs_valid && !outs_ready |=> outs_valid && $stable(outs) && $stable(outs_idx));

endmodule
